// File: rtl/graph_pkg.sv
// Shared vertex type, filter FSM encoding and helpers for the graph-traversal
// visited-filter slice.
package graph_pkg;
    localparam int PROC_BITS = 4;

    typedef logic [31+PROC_BITS:0] vertex_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } filt_state_t;

    localparam logic VISITED_MARK = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction
endpackage

// File: rtl/visited_filter_if.sv
// Candidate, visited-memory and frontier signals of the visited filter,
// bundled so the filter and its environment share one port.
interface visited_filter_if;
    import graph_pkg::*;

    logic    clear_in;
    logic    clear_done_out;
    vertex_t cand_addr_in;
    logic    cand_valid_in;
    logic    cand_ready_out;
    vertex_t v_addr_out;
    logic    v_addr_valid_out;
    logic    write_v_data_out;
    logic    write_v_valid_out;
    logic    visited_in;
    vertex_t next_addr_out;
    logic    next_valid_out;
    logic    next_ready_in;
    logic [15:0] pass_count_out;
    logic [15:0] drop_count_out;

    modport slave (
        input  clear_in, cand_addr_in, cand_valid_in, visited_in, next_ready_in,
        output clear_done_out, cand_ready_out, v_addr_out, v_addr_valid_out,
               write_v_data_out, write_v_valid_out, next_addr_out, next_valid_out,
               pass_count_out, drop_count_out
    );

    modport master (
        output clear_in, cand_addr_in, cand_valid_in, visited_in, next_ready_in,
        input  clear_done_out, cand_ready_out, v_addr_out, v_addr_valid_out,
               write_v_data_out, write_v_valid_out, next_addr_out, next_valid_out,
               pass_count_out, drop_count_out
    );
endinterface

// File: rtl/vf_fifo.sv
// Small synchronous FIFO with occupancy output; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module vf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == CNT_W'(0));
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/visited_filter.sv
// Looks up each candidate's visited bit, marks and forwards first visits,
// drops repeats, and clears the visited memory between traversals.
module visited_filter
    import graph_pkg::*;
#(
    parameter int IDX_BITS  = 10,
    parameter int RD_LAT    = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    visited_filter_if.slave bus
);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = {IDX_BITS{1'b1}};

    filt_state_t         r_state;
    logic [IDX_BITS-1:0] r_clr_idx;
    logic                r_clear_done;
    logic                r_clr_pend;
    logic [15:0]         r_pass_cnt;
    logic [15:0]         r_drop_cnt;
    vertex_t             r_tag_addr [RD_LAT];
    logic [RD_LAT-1:0]   r_tag_vld;
    logic [IDX_BITS-1:0] r_haz_idx [RD_LAT];
    logic [RD_LAT-1:0]   r_haz_vld;

    vertex_t             w_res_addr;
    logic [IDX_BITS-1:0] w_res_idx;
    logic                w_resolve;
    logic                w_hazard;
    logic                w_dup;
    logic                w_mark;
    logic [7:0]          w_inflight;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_fifo_empty;
    logic                w_clr_req;
    logic                w_clr_go;
    logic                w_accept;

    assign w_res_addr = r_tag_addr[RD_LAT-1];
    assign w_res_idx  = w_res_addr[IDX_BITS-1:0];
    assign w_resolve  = r_tag_vld[RD_LAT-1];

    // Reads issued within the last RD_LAT cycles cannot see writes made since,
    // so a resolving index is also checked against recent marks.
    always_comb begin
        w_hazard   = 1'b0;
        w_inflight = 8'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + 8'(r_tag_vld[i]);
            if (r_haz_vld[i] && (r_haz_idx[i] == w_res_idx)) begin
                w_hazard = 1'b1;
            end else begin
                w_hazard = w_hazard;
            end
        end
    end

    assign w_dup     = w_resolve && (bus.visited_in || w_hazard);
    assign w_mark    = w_resolve && !(bus.visited_in || w_hazard);
    assign w_clr_req = bus.clear_in || r_clr_pend;
    assign w_clr_go  = (r_state == RUN) && w_clr_req && (w_inflight == 8'd0) && w_fifo_empty;
    assign bus.cand_ready_out = (r_state == RUN) && !w_clr_req && !w_mark &&
                                ((8'(w_fifo_count) + w_inflight) < 8'(OUT_DEPTH));
    assign w_accept = bus.cand_ready_out && bus.cand_valid_in;

    // Single memory port: clear writes, mark writes, then candidate reads.
    always_comb begin
        bus.v_addr_out        = vertex_t'(0);
        bus.v_addr_valid_out  = 1'b0;
        bus.write_v_data_out  = 1'b0;
        bus.write_v_valid_out = 1'b0;
        case (r_state)
            CLEAR: begin
                bus.v_addr_out        = vertex_t'(r_clr_idx);
                bus.write_v_valid_out = 1'b1;
            end
            RUN: begin
                if (w_mark) begin
                    bus.v_addr_out        = w_res_addr;
                    bus.write_v_data_out  = VISITED_MARK;
                    bus.write_v_valid_out = 1'b1;
                end else if (w_accept) begin
                    bus.v_addr_out       = bus.cand_addr_in;
                    bus.v_addr_valid_out = 1'b1;
                end else begin
                    bus.v_addr_out = vertex_t'(0);
                end
            end
            default: bus.v_addr_out = vertex_t'(0);
        endcase
    end

    // Control FSM: clear sequencing, deferred clear requests and statistics.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= IDLE;
            r_clr_idx    <= {IDX_BITS{1'b0}};
            r_clear_done <= 1'b0;
            r_clr_pend   <= 1'b0;
            r_pass_cnt   <= 16'd0;
            r_drop_cnt   <= 16'd0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.clear_in) begin
                        r_state   <= CLEAR;
                        r_clr_idx <= {IDX_BITS{1'b0}};
                    end
                end
                CLEAR: begin
                    r_clr_idx <= r_clr_idx + IDX_BITS'(1);
                    if (r_clr_idx == LAST_IDX) begin
                        r_state      <= RUN;
                        r_clear_done <= 1'b1;
                        r_pass_cnt   <= 16'd0;
                        r_drop_cnt   <= 16'd0;
                    end
                end
                RUN: begin
                    if (w_clr_go) begin
                        r_state    <= CLEAR;
                        r_clr_idx  <= {IDX_BITS{1'b0}};
                        r_clr_pend <= 1'b0;
                    end else if (bus.clear_in) begin
                        r_clr_pend <= 1'b1;
                    end
                    if (w_mark) begin
                        r_pass_cnt <= sat_inc16(r_pass_cnt);
                    end else if (w_dup) begin
                        r_drop_cnt <= sat_inc16(r_drop_cnt);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read-tag pipeline aligned to the memory latency, plus recent-mark history.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tag_vld <= {RD_LAT{1'b0}};
            r_haz_vld <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_addr[i] <= vertex_t'(0);
                r_haz_idx[i]  <= {IDX_BITS{1'b0}};
            end
        end else begin
            r_tag_vld[0]  <= w_accept;
            r_tag_addr[0] <= bus.cand_addr_in;
            r_haz_vld[0]  <= w_mark;
            r_haz_idx[0]  <= w_res_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_addr[i] <= r_tag_addr[i-1];
                r_haz_vld[i]  <= r_haz_vld[i-1];
                r_haz_idx[i]  <= r_haz_idx[i-1];
            end
        end
    end

    vf_fifo #(
        .WIDTH ($bits(vertex_t)),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .i_push  (w_mark),
        .i_data  (w_res_addr),
        .i_pop   (bus.next_valid_out && bus.next_ready_in),
        .o_data  (bus.next_addr_out),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign bus.next_valid_out = !w_fifo_empty;
    assign bus.clear_done_out = r_clear_done;
    assign bus.pass_count_out = r_pass_cnt;
    assign bus.drop_count_out = r_drop_cnt;
endmodule

// File: tb/tb_visited_filter.sv
// Directed bench for visited_filter with a read-first, two-cycle visited-memory model.
module tb_visited_filter;
    import graph_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    visited_filter_if bus();

    visited_filter dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Memory stores the inverse of the visited bit so power-up reads as "visited".
    bit        mem_n [1024];
    bit        rd0, rd1;
    int        wr7_cnt = 0;
    int        overlap_cnt = 0;
    vertex_t   out_q [$];
    logic [9:0] w_mem_idx;

    assign w_mem_idx     = bus.v_addr_out[9:0];
    assign bus.visited_in = rd1;

    always @(posedge clk) begin
        if (bus.write_v_valid_out === 1'b1) begin
            mem_n[w_mem_idx] <= ~bus.write_v_data_out;
            if (bus.write_v_data_out === 1'b1 && w_mem_idx == 10'd7) wr7_cnt <= wr7_cnt + 1;
        end
        rd0 <= (bus.v_addr_valid_out === 1'b1) ? ~mem_n[w_mem_idx] : 1'b0;
        rd1 <= rd0;
        if (bus.v_addr_valid_out === 1'b1 && bus.write_v_valid_out === 1'b1) overlap_cnt <= overlap_cnt + 1;
    end

    always @(negedge clk) begin
        #3;
        if (rst_n && bus.next_valid_out === 1'b1 && bus.next_ready_in === 1'b1)
            out_q.push_back(bus.next_addr_out);
    end

    task automatic send(input vertex_t a);
        int n = 0;
        bus.cand_addr_in  = a;
        bus.cand_valid_in = 1'b1;
        #1;
        while (bus.cand_ready_out !== 1'b1 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) begin
            errors++; checks++;
            $display("FAIL send_timeout: addr %0h never accepted", a);
        end
        @(negedge clk);
        bus.cand_valid_in = 1'b0;
    endtask

    task automatic do_clear();
        int n = 0;
        @(negedge clk);
        bus.clear_in = 1'b1;
        @(negedge clk);
        bus.clear_in = 1'b0;
        #1;
        while (bus.clear_done_out !== 1'b1 && n < 1200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 1200) begin
            errors++; checks++;
            $display("FAIL clear_timeout: clear_done_out never pulsed");
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.cand_ready_out, bus.v_addr_valid_out, bus.write_v_valid_out,
             bus.next_valid_out, bus.clear_done_out} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {bus.cand_ready_out, bus.v_addr_valid_out,
                     bus.write_v_valid_out, bus.next_valid_out, bus.clear_done_out});
        end
        checks++;
        if (bus.pass_count_out !== 16'd0 || bus.drop_count_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: got pass=%0d drop=%0d expected 0 0", bus.pass_count_out, bus.drop_count_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.cand_valid_in = 1'b1;
        bus.cand_addr_in  = 36'd1;
        @(negedge clk); #1;
        checks++;
        if (bus.cand_ready_out !== 1'b0 || bus.v_addr_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_accept: got ready=%b rd=%b expected 0 0", bus.cand_ready_out, bus.v_addr_valid_out);
        end
        bus.cand_valid_in = 1'b0;
    endtask

    task automatic test_clear();
        int good = 0;
        @(negedge clk);
        bus.clear_in = 1'b1;
        @(negedge clk);
        bus.clear_in = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            #1;
            if (bus.write_v_valid_out === 1'b1 && bus.write_v_data_out === 1'b0 &&
                bus.v_addr_out === 36'(k) && bus.v_addr_valid_out === 1'b0) good++;
            @(negedge clk);
        end
        checks++;
        if (good !== 1024) begin
            errors++;
            $display("FAIL clear_writes: got %0d correct write cycles expected 1024", good);
        end
        #1;
        checks++;
        if (bus.clear_done_out !== 1'b1 || bus.cand_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL clear_done: got done=%b ready=%b expected 1 1", bus.clear_done_out, bus.cand_ready_out);
        end
        checks++;
        if (bus.pass_count_out !== 16'd0 || bus.drop_count_out !== 16'd0) begin
            errors++;
            $display("FAIL clear_counts: got pass=%0d drop=%0d expected 0 0", bus.pass_count_out, bus.drop_count_out);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.clear_done_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_done_pulse: got %b expected 0", bus.clear_done_out);
        end
    endtask

    task automatic test_basic();
        int base;
        @(negedge clk);
        base = out_q.size();
        bus.next_ready_in = 1'b1;
        send(36'd5);
        #1;
        checks++;
        if (bus.next_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL early_valid: got %b expected 0", bus.next_valid_out);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.write_v_valid_out !== 1'b1 || bus.write_v_data_out !== 1'b1 || bus.v_addr_out !== 36'd5) begin
            errors++;
            $display("FAIL mark_write: got we=%b wd=%b addr=%0h expected 1 1 5",
                     bus.write_v_valid_out, bus.write_v_data_out, bus.v_addr_out);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.next_valid_out !== 1'b1 || bus.next_addr_out !== 36'd5) begin
            errors++;
            $display("FAIL latency: got valid=%b addr=%0h expected 1 5", bus.next_valid_out, bus.next_addr_out);
        end
        repeat (3) @(negedge clk);
        send(36'd9);
        repeat (4) @(negedge clk);
        send(36'd5);
        repeat (6) @(negedge clk);
        checks++;
        if (out_q.size() != base + 2 || out_q[base] !== 36'd5 || out_q[base+1] !== 36'd9) begin
            errors++;
            $display("FAIL basic_outputs: got %0d new outputs expected 5 then 9", out_q.size() - base);
        end
        checks++;
        if (bus.pass_count_out !== 16'd2 || bus.drop_count_out !== 16'd1) begin
            errors++;
            $display("FAIL basic_counts: got pass=%0d drop=%0d expected 2 1", bus.pass_count_out, bus.drop_count_out);
        end
    endtask

    task automatic test_back_to_back();
        int base, w7;
        do_clear();
        base = out_q.size();
        w7   = wr7_cnt;
        send(36'd7);
        send(36'd7);
        send(36'd7);
        repeat (8) @(negedge clk);
        checks++;
        if (out_q.size() != base + 1 || out_q[base] !== 36'd7) begin
            errors++;
            $display("FAIL hazard_outputs: got %0d new outputs expected one 7", out_q.size() - base);
        end
        checks++;
        if (bus.pass_count_out !== 16'd1 || bus.drop_count_out !== 16'd2) begin
            errors++;
            $display("FAIL hazard_counts: got pass=%0d drop=%0d expected 1 2", bus.pass_count_out, bus.drop_count_out);
        end
        checks++;
        if (wr7_cnt - w7 !== 1) begin
            errors++;
            $display("FAIL hazard_writes: got %0d marks of index 7 expected 1", wr7_cnt - w7);
        end
    endtask

    task automatic test_index_alias();
        int base;
        do_clear();
        base = out_q.size();
        send(36'h1_0000_0003);
        repeat (4) @(negedge clk);
        send(36'h2_0000_0003);
        repeat (6) @(negedge clk);
        checks++;
        if (out_q.size() != base + 1 || out_q[base] !== 36'h1_0000_0003) begin
            errors++;
            $display("FAIL alias_outputs: got %0d new outputs expected one 100000003", out_q.size() - base);
        end
        checks++;
        if (bus.pass_count_out !== 16'd1 || bus.drop_count_out !== 16'd1) begin
            errors++;
            $display("FAIL alias_counts: got pass=%0d drop=%0d expected 1 1", bus.pass_count_out, bus.drop_count_out);
        end
    endtask

    task automatic test_backpressure();
        int base, bad;
        do_clear();
        base = out_q.size();
        bus.next_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) send(36'(100 + i));
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (bus.cand_ready_out !== 1'b0 || bus.next_valid_out !== 1'b1 || bus.next_addr_out !== 36'd100) begin
            errors++;
            $display("FAIL bp_stall: got ready=%b valid=%b head=%0h expected 0 1 64",
                     bus.cand_ready_out, bus.next_valid_out, bus.next_addr_out);
        end
        checks++;
        if (bus.pass_count_out !== 16'd4 || out_q.size() != base) begin
            errors++;
            $display("FAIL bp_held: got pass=%0d popped=%0d expected 4 0", bus.pass_count_out, out_q.size() - base);
        end
        @(negedge clk);
        bus.next_ready_in = 1'b1;
        for (int i = 4; i < 10; i++) send(36'(100 + i));
        repeat (12) @(negedge clk);
        bad = 0;
        if (out_q.size() != base + 10) bad = 1;
        else for (int i = 0; i < 10; i++) if (out_q[base+i] !== 36'(100 + i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_order: got %0d outputs with %0d bad expected 10 in order", out_q.size() - base, bad);
        end
    endtask

    task automatic test_clear_deferred();
        int base, n;
        @(negedge clk);
        base = out_q.size();
        send(36'd300);
        bus.clear_in = 1'b1;
        #1;
        checks++;
        if (bus.cand_ready_out !== 1'b0 || bus.write_v_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL defer_hold: got ready=%b we=%b expected 0 0", bus.cand_ready_out, bus.write_v_valid_out);
        end
        @(negedge clk);
        bus.clear_in = 1'b0;
        #1;
        checks++;
        if (bus.write_v_valid_out !== 1'b1 || bus.write_v_data_out !== 1'b1 || bus.v_addr_out !== 36'd300) begin
            errors++;
            $display("FAIL defer_mark: got we=%b wd=%b addr=%0h expected 1 1 12c",
                     bus.write_v_valid_out, bus.write_v_data_out, bus.v_addr_out);
        end
        n = 0;
        while (bus.clear_done_out !== 1'b1 && n < 1200) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (n >= 1200) begin
            errors++;
            $display("FAIL defer_done: got no clear_done_out within 1200 cycles expected a pulse");
        end
        checks++;
        if (out_q.size() != base + 1 || out_q[base] !== 36'd300 || bus.pass_count_out !== 16'd0) begin
            errors++;
            $display("FAIL defer_result: got %0d outputs pass=%0d expected one 12c and 0",
                     out_q.size() - base, bus.pass_count_out);
        end
    endtask

    task automatic test_reset_midrun();
        int base;
        @(negedge clk);
        base = out_q.size();
        send(36'd200);
        send(36'd201);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cand_ready_out, bus.v_addr_valid_out, bus.write_v_valid_out, bus.next_valid_out} !== 4'b0 ||
            bus.v_addr_out !== 36'd0) begin
            errors++;
            $display("FAIL midrun_reset: got ready/rd/we/valid=%b addr=%0h expected 0000 0",
                     {bus.cand_ready_out, bus.v_addr_valid_out, bus.write_v_valid_out, bus.next_valid_out}, bus.v_addr_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.cand_addr_in  = 36'd202;
        bus.cand_valid_in = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (bus.cand_ready_out !== 1'b0 || bus.next_valid_out !== 1'b0 || bus.v_addr_valid_out !== 1'b0 ||
            bus.write_v_valid_out !== 1'b0 || out_q.size() != base) begin
            errors++;
            $display("FAIL post_reset_idle: got ready=%b valid=%b emitted=%0d expected 0 0 0",
                     bus.cand_ready_out, bus.next_valid_out, out_q.size() - base);
        end
        bus.cand_valid_in = 1'b0;
    endtask

    task automatic test_port_exclusive();
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL port_overlap: got %0d read+write cycles expected 0", overlap_cnt);
        end
    endtask

    initial begin
        bus.clear_in      = 1'b0;
        bus.cand_addr_in  = 36'd0;
        bus.cand_valid_in = 1'b0;
        bus.next_ready_in = 1'b1;
        test_reset();
        test_clear();
        test_basic();
        test_back_to_back();
        test_index_alias();
        test_backpressure();
        test_clear_deferred();
        test_reset_midrun();
        test_port_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/visited_filter.md
Name: visited_filter

Overview:
- Sits directly upstream of the checked/visited memory in the graph-traversal datapath.
- Accepts a stream of candidate neighbour vertex addresses from edge fetch and looks up each one's visited bit.
- Unvisited vertices are marked visited and forwarded to the frontier queue; visited vertices are dropped.
- Owns clearing the visited memory between traversals and resolves read-after-write hazards caused by the memory's fixed read latency.

Parameters:
- PROC_BITS, 4, extra high address bits carried with each vertex (vertex word is 32+PROC_BITS bits).
- IDX_BITS, 10, low address bits used as the visited-memory index (depth 2**IDX_BITS).
- RD_LAT, 2, visited-memory read latency in cycles (read-first, registered output).
- OUT_DEPTH, 4, output FIFO entries.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-low
- clear_in  in  1  pulse: start clearing the visited memory
- clear_done_out  out  1  one-cycle pulse when clearing finishes
- cand_addr_in  in  32+PROC_BITS  candidate vertex
- cand_valid_in  in  1  candidate valid
- cand_ready_out  out  1  candidate accepted when valid&&ready
- v_addr_out  out  32+PROC_BITS  visited-memory address
- v_addr_valid_out  out  1  read strobe
- write_v_data_out  out  1  write data
- write_v_valid_out  out  1  write enable
- visited_in  in  1  visited-memory read data
- next_addr_out  out  32+PROC_BITS  unvisited vertex to frontier
- next_valid_out  out  1  output valid
- next_ready_in  in  1  downstream ready
- pass_count_out  out  16  vertices forwarded since last clear
- drop_count_out  out  16  vertices dropped since last clear

Behaviour:
- Reset (rst_in low, asynchronous): FSM=IDLE; all outputs 0; pipeline, hazard shift registers, FIFO and counters are emptied/zeroed.
- FSM states:
  - IDLE: cand_ready_out=0. clear_in -> CLEAR.
  - CLEAR: each cycle drives v_addr_out=clr_idx, write_v_data_out=0, write_v_valid_out=1. clr_idx counts from 0 to 2**IDX_BITS-1. After the last index: clear_done_out pulses, both counters zero, FSM -> RUN.
  - RUN: filtering. clear_in -> CLEAR only when no read is in flight and the FIFO is empty; otherwise the request is latched and taken at the first such cycle. clear_in during CLEAR is ignored.
- Issue (RUN):
  - cand_ready_out = (fifo_count + inflight) < OUT_DEPTH.
  - On accept: v_addr_out=cand_addr_in, v_addr_valid_out=1, write_v_valid_out=0.
  - The address enters an RD_LAT-deep tag pipeline. One accept per cycle maximum.
- Resolve: RD_LAT cycles after issue, visited_in is sampled for that tag. The candidate is a duplicate if visited_in=1, or if its index matches any index marked in the previous RD_LAT cycles (hazard shift register of index+valid).
- Mark:
  - A non-duplicate is written with write_v_data_out=1 and write_v_valid_out=1 in the resolve cycle, pushed into the FIFO, recorded in the hazard register, and pass_count increments.
  - A duplicate increments drop_count.
  - Counters saturate at 16'hFFFF.
- Port sharing: a write in the resolve cycle takes the memory port; issue is stalled (cand_ready_out=0) that cycle. Read and write never overlap.
- Comparison: only the IDX_BITS low bits are compared; the full 32+PROC_BITS word is forwarded unchanged.
- Output: FIFO with next_valid_out = !empty.
  - Pop on next_valid_out && next_ready_in.
  - Push and pop in the same cycle are both allowed when the FIFO is full.
  - The credit rule guarantees no overflow.
- Latency: accept-to-next_valid_out = RD_LAT+1 cycles with an empty FIFO.

Decomposition:
- Shared package graph_pkg:
  - vertex_t (logic [31+PROC_BITS:0]);
  - typedef filt_state_t {IDLE, CLEAR, RUN};
  - constant VISITED_MARK=1'b1.
- One sub-module: vf_fifo, a parameterised sync FIFO with count output.

Test Plan:
- Reset then clear_in pulse -> 1024 consecutive write cycles with data 0, clear_done_out high at cycle 1025, FSM in RUN, counters 0.
- Candidates 5, 9, 5 spaced 4 cycles apart, next_ready_in=1 -> outputs 5, 9; pass=2, drop=1.
- Back-to-back candidates 7, 7, 7 (hazard window) -> exactly one 7 output; drop_count=2; memory index 7 written once.
- Candidates 0x1_0000_0003 and 0x2_0000_0003 -> second dropped (same index 3); first forwarded with upper bits intact.
- next_ready_in=0 with 10 distinct candidates -> cand_ready_out falls after 4 accepts; FIFO holds 4; releasing ready outputs all 10 in order, none lost.
- rst_in asserted low mid-RUN with 2 reads in flight -> outputs 0 immediately; after release the FSM is in IDLE and nothing is emitted.
